hdd_sector_server: RTL and testbench

HDD_SECTOR_SERVER -- requirements
Module: hdd_sector_server

---
 rtl/hdd_sector_server.sv | 205 ++++++++++++++++++++
 tb/tb_hdd_sector_server.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdd_sector_server.sv
// Sector server between an HDD controller and a block device.
// A rising edge on hdd_read moves one 512-byte sector from the block device
// into the sector buffer. If no image is mounted, the buffer is zero-filled
// instead. A rising edge on hdd_write streams the buffer out to the block device.
// Ports:
//   CLK_14M, reset_n                      clock, async active-low reset
//   hdd_sector, hdd_read, hdd_write       controller requests (edge-triggered)
//   img_mounted, img_readonly             host image status
//   hdd_mounted, hdd_protect              registered copies of the image status
//   buf_addr, buf_di, buf_we, buf_do      sector buffer port (buf_do one cycle after buf_addr)
//   blk_lba, blk_rd, blk_wr, blk_ack      block-device command handshake
//   blk_rdata, blk_rvalid                 read byte stream
//   blk_wdata, blk_wvalid, blk_wready     write byte stream
//   busy, done                            status, one-cycle completion pulse
module hdd_sector_server (
  input  logic        CLK_14M,
  input  logic        reset_n,
  input  logic [15:0] hdd_sector,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic        img_mounted,
  input  logic        img_readonly,
  output logic        hdd_mounted,
  output logic        hdd_protect,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_di,
  output logic        buf_we,
  input  logic [7:0]  buf_do,
  output logic [15:0] blk_lba,
  output logic        blk_rd,
  output logic        blk_wr,
  input  logic        blk_ack,
  input  logic [7:0]  blk_rdata,
  input  logic        blk_rvalid,
  output logic [7:0]  blk_wdata,
  output logic        blk_wvalid,
  input  logic        blk_wready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdData, StZeroFill, StWrReq, StWrFetch, StWrData, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] lba_q, lba_d;
  logic        rd_prev_q, wr_prev_q;
  // Cleared by reset. Suppresses edges for one cycle so that a level still
  // high after reset release is not taken as a new request.
  logic        armed_q;
  logic        pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [15:0] pend_rd_sec_q, pend_rd_sec_d, pend_wr_sec_q, pend_wr_sec_d;
  // High in the first WR_DATA cycle, when buf_do carries the fetched byte.
  logic        wfirst_q, wfirst_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        mounted_q, protect_q;

  logic        rd_edge, wr_edge, rd_go, wr_go;
  logic [15:0] rd_sec, wr_sec;

  // State and datapath registers
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      lba_q         <= '0;
      rd_prev_q     <= 1'b0;
      wr_prev_q     <= 1'b0;
      armed_q       <= 1'b0;
      pend_rd_q     <= 1'b0;
      pend_wr_q     <= 1'b0;
      pend_rd_sec_q <= '0;
      pend_wr_sec_q <= '0;
      wfirst_q      <= 1'b0;
      wdata_q       <= '0;
      mounted_q     <= 1'b0;
      protect_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lba_q         <= lba_d;
      rd_prev_q     <= hdd_read;
      wr_prev_q     <= hdd_write;
      armed_q       <= 1'b1;
      pend_rd_q     <= pend_rd_d;
      pend_wr_q     <= pend_wr_d;
      pend_rd_sec_q <= pend_rd_sec_d;
      pend_wr_sec_q <= pend_wr_sec_d;
      wfirst_q      <= wfirst_d;
      wdata_q       <= wdata_d;
      mounted_q     <= img_mounted;
      protect_q     <= img_readonly;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lba_d         = lba_q;
    pend_rd_d     = pend_rd_q;
    pend_wr_d     = pend_wr_q;
    pend_rd_sec_d = pend_rd_sec_q;
    pend_wr_sec_d = pend_wr_sec_q;
    wfirst_d      = 1'b0;
    wdata_d       = wfirst_q ? buf_do : wdata_q;

    rd_edge = hdd_read & ~rd_prev_q & armed_q;
    wr_edge = hdd_write & ~wr_prev_q & armed_q;
    // A fresh edge in IDLE supersedes an older pending request of the same kind.
    rd_go   = rd_edge | pend_rd_q;
    wr_go   = wr_edge | pend_wr_q;
    rd_sec  = rd_edge ? hdd_sector : pend_rd_sec_q;
    wr_sec  = wr_edge ? hdd_sector : pend_wr_sec_q;

    if (state_q != StIdle) begin
      if (rd_edge) begin
        pend_rd_d     = 1'b1;
        pend_rd_sec_d = hdd_sector;
      end
      if (wr_edge) begin
        pend_wr_d     = 1'b1;
        pend_wr_sec_d = hdd_sector;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (rd_go) begin
          lba_d     = rd_sec;
          cnt_d     = '0;
          pend_rd_d = 1'b0;
          // Read wins a tie; the write waits with its own sector.
          if (wr_edge) begin
            pend_wr_d     = 1'b1;
            pend_wr_sec_d = hdd_sector;
          end
          state_d = mounted_q ? StRdReq : StZeroFill;
        end else if (wr_go) begin
          lba_d     = wr_sec;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
          state_d   = (mounted_q && !protect_q) ? StWrReq : StDone;
        end
      end
      StRdReq: begin
        if (blk_ack) begin
          cnt_d   = '0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (blk_rvalid) begin
          if (cnt_q == 9'd511) state_d = StDone;
          else                 cnt_d   = cnt_q + 9'd1;
        end
      end
      StZeroFill: begin
        if (cnt_q == 9'd511) state_d = StDone;
        else                 cnt_d   = cnt_q + 9'd1;
      end
      StWrReq: begin
        if (blk_ack) begin
          cnt_d   = '0;
          state_d = StWrFetch;
        end
      end
      StWrFetch: begin
        wfirst_d = 1'b1;
        state_d  = StWrData;
      end
      StWrData: begin
        if (blk_wready) begin
          if (cnt_q == 9'd511) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 9'd1;
            state_d = StWrFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    blk_rd      = (state_q == StRdReq);
    blk_wr      = (state_q == StWrReq);
    blk_wvalid  = (state_q == StWrData);
    buf_we      = ((state_q == StRdData) && blk_rvalid) || (state_q == StZeroFill);
    buf_di      = ((state_q == StRdData) && blk_rvalid) ? blk_rdata : 8'h00;
    buf_addr    = cnt_q;
    blk_wdata   = wfirst_q ? buf_do : wdata_q;
    blk_lba     = lba_q;
    hdd_mounted = mounted_q;
    hdd_protect = protect_q;
  end

endmodule

// File: tb/tb_hdd_sector_server.sv
module tb_hdd_sector_server;

  logic        CLK_14M = 1'b0;
  logic        reset_n;
  logic [15:0] hdd_sector;
  logic        hdd_read, hdd_write, img_mounted, img_readonly;
  logic        hdd_mounted, hdd_protect;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_di, buf_do;
  logic        buf_we;
  logic [15:0] blk_lba;
  logic        blk_rd, blk_wr, blk_ack;
  logic [7:0]  blk_rdata, blk_wdata;
  logic        blk_rvalid, blk_wvalid, blk_wready;
  logic        busy, done;

  always #5 CLK_14M = ~CLK_14M;

  hdd_sector_server dut (
    .CLK_14M     (CLK_14M),
    .reset_n     (reset_n),
    .hdd_sector  (hdd_sector),
    .hdd_read    (hdd_read),
    .hdd_write   (hdd_write),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .hdd_mounted (hdd_mounted),
    .hdd_protect (hdd_protect),
    .buf_addr    (buf_addr),
    .buf_di      (buf_di),
    .buf_we      (buf_we),
    .buf_do      (buf_do),
    .blk_lba     (blk_lba),
    .blk_rd      (blk_rd),
    .blk_wr      (blk_wr),
    .blk_ack     (blk_ack),
    .blk_rdata   (blk_rdata),
    .blk_rvalid  (blk_rvalid),
    .blk_wdata   (blk_wdata),
    .blk_wvalid  (blk_wvalid),
    .blk_wready  (blk_wready),
    .busy        (busy),
    .done        (done)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Sector buffer: synchronous read-first RAM.
  logic [7:0] mem [512];
  always @(posedge CLK_14M) begin
    buf_do <= mem[buf_addr];
    if (buf_we) mem[buf_addr] = buf_di;
  end

  // Scoreboards: expected buffer writes {addr,data} and expected write-stream bytes.
  logic [16:0] exp_wq[$];
  logic [7:0]  exp_sq[$];
  logic [16:0] mon_e;
  logic [7:0]  mon_s;
  int done_cnt = 0;
  int accept_cnt = 0;
  bit rd_seen, wr_seen, busy_seen;

  always @(negedge CLK_14M) begin
    if (reset_n) begin
      if (blk_rd) rd_seen = 1'b1;
      if (blk_wr) wr_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) done_cnt++;
      if (buf_we) begin
        tests_run++;
        if (exp_wq.size() == 0) begin
          tests_failed++;
          $display("FAIL buf_write: got addr=%0d data=%h, required no write", buf_addr, buf_di);
        end else begin
          mon_e = exp_wq.pop_front();
          if ({buf_addr, buf_di} !== mon_e) begin
            tests_failed++;
            $display("FAIL buf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     buf_addr, buf_di, mon_e[16:8], mon_e[7:0]);
          end
        end
      end
      if (blk_wvalid && blk_wready) begin
        accept_cnt++;
        tests_run++;
        if (exp_sq.size() == 0) begin
          tests_failed++;
          $display("FAIL wr_stream: got extra byte %h, required none", blk_wdata);
        end else begin
          mon_s = exp_sq.pop_front();
          if (blk_wdata !== mon_s) begin
            tests_failed++;
            $display("FAIL wr_stream: got %h, required %h", blk_wdata, mon_s);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK_14M);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      tick();
      c++;
    end
    tick();
    tick();
    tests_run++;
    if (done_cnt !== target) begin
      tests_failed++;
      $display("FAIL %s: done pulses got %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({busy, done, blk_rd, blk_wr, blk_wvalid, buf_we, blk_lba, buf_addr, buf_di, blk_wdata,
         hdd_mounted, hdd_protect} !== '0) begin
      tests_failed++;
      $display("FAIL %s: busy=%b done=%b rd=%b wr=%b wv=%b we=%b lba=%h addr=%h di=%h wd=%h m=%b p=%b, required all 0",
               name, busy, done, blk_rd, blk_wr, blk_wvalid, buf_we, blk_lba, buf_addr, buf_di,
               blk_wdata, hdd_mounted, hdd_protect);
    end
  endtask

  // Services a read already requested by an edge: acks after 3 cycles and
  // streams byte n = n ^ xr. Optionally aborts with reset at byte abort_at, or
  // re-edges hdd_write with sector 9 mid-transfer.
  task automatic run_read(input logic [15:0] sec, input logic [7:0] xr, input int abort_at,
                          input bit rewrite);
    int c = 0;
    while (!blk_rd && c < 20) begin
      tick();
      c++;
    end
    tests_run++;
    if (blk_rd !== 1'b1 || blk_lba !== sec) begin
      tests_failed++;
      $display("FAIL rd_req: got blk_rd=%b lba=%h, required 1 lba=%h", blk_rd, blk_lba, sec);
    end
    repeat (3) tick();
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    for (int n = 0; n < 512; n++) begin
      if (n == abort_at) begin
        reset_n    = 1'b0;
        blk_rvalid = 1'b0;
        #1;
        return;
      end
      if (rewrite) begin
        if (n == 10) hdd_write = 1'b0;
        if (n == 12) begin
          hdd_sector = 16'd9;
          hdd_write  = 1'b1;
        end
        if (n == 13) hdd_write = 1'b0;
      end
      if (n % 37 == 5) begin
        blk_rvalid = 1'b0;
        blk_rdata  = 8'hEE;
        tick();
      end
      exp_wq.push_back({9'(n), 8'(n) ^ xr});
      blk_rvalid = 1'b1;
      blk_rdata  = 8'(n) ^ xr;
      tick();
    end
    blk_rvalid = 1'b0;
  endtask

  // Services a write already requested; stream expectations must be queued.
  task automatic run_write(input logic [15:0] sec, input bit toggle, input int target);
    int c = 0;
    int a0 = accept_cnt;
    while (!blk_wr && c < 20) begin
      tick();
      c++;
    end
    tests_run++;
    if (blk_wr !== 1'b1 || blk_lba !== sec) begin
      tests_failed++;
      $display("FAIL wr_req: got blk_wr=%b lba=%h, required 1 lba=%h", blk_wr, blk_lba, sec);
    end
    tick();
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    c = 0;
    while (done_cnt < target && c < 5000) begin
      blk_wready = toggle ? (c % 2 == 1) : 1'b1;
      tick();
      c++;
    end
    blk_wready = 1'b0;
    tests_run++;
    if (accept_cnt - a0 !== 512 || exp_sq.size() !== 0) begin
      tests_failed++;
      $display("FAIL wr_count: got %0d bytes, %0d left unsent, required 512 and 0",
               accept_cnt - a0, exp_sq.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hdd_sector = '0; hdd_read = 0; hdd_write = 0;
    img_mounted = 1'b1; img_readonly = 1'b0;
    blk_ack = 0; blk_rdata = 8'h5A; blk_rvalid = 0; blk_wready = 0;
    tick();
    tick();
    check_all_zero("reset_state");
    reset_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (hdd_mounted !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mount_copy: got mounted=%b busy=%b, required 1 0", hdd_mounted, busy);
    end
  endtask

  task automatic test_read();
    int d0 = done_cnt;
    hdd_sector = 16'h0123;
    hdd_read   = 1'b1;
    tick();
    hdd_read = 1'b0;
    run_read(16'h0123, 8'h00, -1, 1'b0);
    wait_done(d0 + 1, 20, "read_done");
    tests_run++;
    if (mem[0] !== 8'h00 || mem[200] !== 8'hC8 || mem[511] !== 8'hFF || exp_wq.size() != 0) begin
      tests_failed++;
      $display("FAIL read_buffer: got %h %h %h left=%0d, required 00 c8 ff 0",
               mem[0], mem[200], mem[511], exp_wq.size());
    end
  endtask

  task automatic test_write();
    int d0 = done_cnt;
    for (int n = 0; n < 512; n++) begin
      mem[n] = 8'hA5 ^ 8'(n);
      exp_sq.push_back(8'hA5 ^ 8'(n));
    end
    hdd_sector = 16'h0042;
    hdd_write  = 1'b1;
    tick();
    hdd_write = 1'b0;
    run_write(16'h0042, 1'b1, d0 + 1);
    wait_done(d0 + 1, 10, "write_done");
  endtask

  task automatic test_readonly_and_zero();
    int d0 = done_cnt;
    int c = 0;
    img_readonly = 1'b1;
    tick();
    tick();
    tests_run++;
    if (hdd_protect !== 1'b1) begin
      tests_failed++;
      $display("FAIL protect_copy: got %b, required 1", hdd_protect);
    end
    wr_seen    = 1'b0;
    hdd_sector = 16'h0031;
    hdd_write  = 1'b1;
    tick();
    hdd_write = 1'b0;
    while (done_cnt == d0 && c < 10) begin
      tick();
      c++;
    end
    tests_run++;
    if (done_cnt !== d0 + 1 || c > 3 || wr_seen) begin
      tests_failed++;
      $display("FAIL readonly_write: got done=%0d after %0d cycles blk_wr_seen=%b, required 1 within 3, 0",
               done_cnt - d0, c, wr_seen);
    end
    img_readonly = 1'b0;
    img_mounted  = 1'b0;
    tick();
    tick();
    tests_run++;
    if (hdd_mounted !== 1'b0) begin
      tests_failed++;
      $display("FAIL mount_copy_off: got %b, required 0", hdd_mounted);
    end
    rd_seen = 1'b0;
    for (int n = 0; n < 512; n++) exp_wq.push_back({9'(n), 8'h00});
    hdd_sector = 16'h0044;
    hdd_read   = 1'b1;
    tick();
    hdd_read = 1'b0;
    wait_done(d0 + 2, 600, "zero_fill_done");
    tests_run++;
    if (exp_wq.size() !== 0 || rd_seen || mem[77] !== 8'h00) begin
      tests_failed++;
      $display("FAIL zero_fill: got %0d writes missing blk_rd_seen=%b mem77=%h, required 0 0 00",
               exp_wq.size(), rd_seen, mem[77]);
    end
    img_mounted = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    for (int n = 0; n < 512; n++) exp_sq.push_back(8'(n) ^ 8'h3C);
    hdd_sector = 16'd5;
    hdd_read   = 1'b1;
    hdd_write  = 1'b1;
    tick();
    hdd_read = 1'b0;
    run_read(16'd5, 8'h3C, -1, 1'b1);
    wait_done(d0 + 1, 20, "b2b_read_done");
    run_write(16'd9, 1'b0, d0 + 2);
    wait_done(d0 + 2, 10, "b2b_write_done");
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int c = 0;
    hdd_sector = 16'h0077;
    hdd_read   = 1'b1;
    tick();
    run_read(16'h0077, 8'h11, 200, 1'b0);
    check_all_zero("abort_outputs");
    tick();
    tick();
    check_all_zero("abort_held");
    reset_n   = 1'b1;
    busy_seen = 1'b0;
    rd_seen   = 1'b0;
    repeat (20) tick();
    tests_run++;
    if (busy_seen || rd_seen || done_cnt !== d0 || exp_wq.size() !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_restart: got busy=%b rd=%b done=%0d left=%0d, required 0 0 0 0",
               busy_seen, rd_seen, done_cnt - d0, exp_wq.size());
    end
    hdd_read = 1'b0;
    tick();
    hdd_sector = 16'h0078;
    hdd_read   = 1'b1;
    tick();
    hdd_read = 1'b0;
    run_read(16'h0078, 8'h22, -1, 1'b0);
    wait_done(d0 + 1, 20, "post_abort_done");
    c = exp_wq.size();
    tests_run++;
    if (c !== 0) begin
      tests_failed++;
      $display("FAIL post_abort_read: got %0d writes missing, required 0", c);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_readonly_and_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
